mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single memory controller between the instruction-fetch unit (port F, read-only) and the load/store unit (port D, read/write).
- Sits between the pipeline front/back ends and the memory controller.
- Latches the winning request, sequences the controller's exec/ready/data_ready handshake, and returns a one-cycle ack with read data to the winner.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port IDs and access size codes.
package mem_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Requester identifiers, also used as the grant / last-grant encoding
  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Access size codes understood by the memory controller
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Address and data widths of both requester ports and the controller
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// A lone requester always wins. On a tie the port that did not receive the
// previous grant wins; with last_grant_i tied to PORT_F this degenerates to
// fixed D-over-F priority.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic F_req_i,
  input  logic D_req_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_port_o
);

  // Pick a winner among the pending requests
  always_comb begin
    grant_valid_o = F_req_i | D_req_i;
    grant_port_o  = PORT_F;
    if (F_req_i && D_req_i) begin
      grant_port_o = (last_grant_i == PORT_D) ? PORT_F : PORT_D;
    end else if (D_req_i) begin
      grant_port_o = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory controller between instruction fetch
// (port F, read-only) and load/store (port D, read/write).
// Optional build macro: MEM_ARB_RR_EN -- round-robin tie breaking using a
// one-bit last-grant register; undefined gives fixed D-over-F priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [1:0] FETCH_SIZE = SIZE_HALF
) (
  input  logic              I_clk,
  input  logic              I_reset,
  // fetch port
  input  logic              F_req,
  input  logic [ADDR_W-1:0] F_addr,
  output logic              F_ack,
  output logic [DATA_W-1:0] F_data,
  // load/store port
  input  logic              D_req,
  input  logic              D_write,
  input  logic [1:0]        D_size,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_data,
  output logic              D_ack,
  output logic [DATA_W-1:0] D_rdata,
  // status
  output logic              O_busy,
  // memory controller
  output logic              C_exec,
  output logic              C_write,
  output logic [1:0]        C_size,
  output logic [ADDR_W-1:0] C_addr,
  output logic [DATA_W-1:0] C_data,
  input  logic [DATA_W-1:0] C_rdata,
  input  logic              C_data_ready,
  input  logic              C_ready
);

  state_t              state_q;
  logic                grant_q;       // port owning the current transaction
  logic                first_wait_q;  // set during the first WAIT cycle
  logic                busy_q;
  logic                exec_q;
  logic                f_ack_q;
  logic                d_ack_q;
  logic [DATA_W-1:0]   f_data_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                c_write_q;
  logic [1:0]          c_size_q;
  logic [ADDR_W-1:0]   c_addr_q;
  logic [DATA_W-1:0]   c_data_q;

  logic                pick_valid;
  logic                pick_port;
  logic                last_grant;
  logic                grant_now;

  // A grant happens only from IDLE with the controller ready
  assign grant_now = (state_q == ST_IDLE) && C_ready && pick_valid;

`ifdef MEM_ARB_RR_EN
  logic last_q;
  logic last_d;

  assign last_d = grant_now ? pick_port : last_q;

  // Remember the most recent winner; resetting to F makes D win the first tie
  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      last_q <= PORT_F;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_grant = last_q;
`else
  // Pretending F always won last keeps D ahead on every tie
  assign last_grant = PORT_F;
`endif

  mem_arb_pick u_pick (
    .F_req_i       (F_req),
    .D_req_i       (D_req),
    .last_grant_i  (last_grant),
    .grant_valid_o (pick_valid),
    .grant_port_o  (pick_port)
  );

  // Transaction sequencer with registered controller and requester outputs
  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= PORT_F;
      first_wait_q <= 1'b0;
      busy_q       <= 1'b0;
      exec_q       <= 1'b0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      f_data_q     <= '0;
      d_rdata_q    <= '0;
      c_write_q    <= 1'b0;
      c_size_q     <= '0;
      c_addr_q     <= '0;
      c_data_q     <= '0;
    end else begin
      // strobes are single-cycle unless re-asserted below
      exec_q  <= 1'b0;
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_now) begin
            grant_q <= pick_port;
            if (pick_port == PORT_D) begin
              c_write_q <= D_write;
              c_size_q  <= D_size;
              c_addr_q  <= D_addr;
              c_data_q  <= D_data;
            end else begin
              // fetches are always half-word style reads with no store data
              c_write_q <= 1'b0;
              c_size_q  <= FETCH_SIZE;
              c_addr_q  <= F_addr;
              c_data_q  <= '0;
            end
            // exec is visible during the ISSUE cycle itself
            exec_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          first_wait_q <= 1'b1;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          first_wait_q <= 1'b0;
          if (c_write_q) begin
            // controller still shows ready for a cycle after exec, so the
            // first WAIT cycle cannot signal store completion
            if (C_ready && !first_wait_q) begin
              d_ack_q <= 1'b1;
              state_q <= ST_DONE;
            end
          end else if (C_data_ready) begin
            if (grant_q == PORT_D) begin
              d_rdata_q <= C_rdata;
              d_ack_q   <= 1'b1;
            end else begin
              f_data_q <= C_rdata;
              f_ack_q  <= 1'b1;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // requests are ignored here so requesters can drop or change req
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign F_ack   = f_ack_q;
  assign F_data  = f_data_q;
  assign D_ack   = d_ack_q;
  assign D_rdata = d_rdata_q;
  assign O_busy  = busy_q;
  assign C_exec  = exec_q;
  assign C_write = c_write_q;
  assign C_size  = c_size_q;
  assign C_addr  = c_addr_q;
  assign C_data  = c_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural controller model,
// scoreboards for controller exec strobes and requester acks.
module tb_mem_arbiter;
  import mem_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [1:0]  sz;
    logic [15:0] data;
  } exe_t;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } ack_t;

  logic        clk;
  logic        I_reset;
  logic        F_req;
  logic [15:0] F_addr;
  logic        F_ack;
  logic [15:0] F_data;
  logic        D_req;
  logic        D_write;
  logic [1:0]  D_size;
  logic [15:0] D_addr;
  logic [15:0] D_data;
  logic        D_ack;
  logic [15:0] D_rdata;
  logic        O_busy;
  logic        C_exec;
  logic        C_write;
  logic [1:0]  C_size;
  logic [15:0] C_addr;
  logic [15:0] C_data;
  logic [15:0] C_rdata;
  logic        C_data_ready;
  logic        C_ready;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   lat = 2;
  logic hang = 1'b0;
  logic hold_nr = 1'b0;

  exe_t exq[$];
  ack_t sbq[$];
  int   exec_hist[$];
  int   ack_hist[$];

  mem_arbiter dut (
    .I_clk        (clk),
    .I_reset      (I_reset),
    .F_req        (F_req),
    .F_addr       (F_addr),
    .F_ack        (F_ack),
    .F_data       (F_data),
    .D_req        (D_req),
    .D_write      (D_write),
    .D_size       (D_size),
    .D_addr       (D_addr),
    .D_data       (D_data),
    .D_ack        (D_ack),
    .D_rdata      (D_rdata),
    .O_busy       (O_busy),
    .C_exec       (C_exec),
    .C_write      (C_write),
    .C_size       (C_size),
    .C_addr       (C_addr),
    .C_data       (C_data),
    .C_rdata      (C_rdata),
    .C_data_ready (C_data_ready),
    .C_ready      (C_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0100) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Controller model: keeps ready one cycle after exec, then busy for lat-1 cycles
  initial begin
    logic        pw;
    logic [15:0] pa;
    int          phase;
    int          cnt;
    C_ready = 1'b1; C_data_ready = 1'b0; C_rdata = '0;
    phase = 0; cnt = 0; pw = 1'b0; pa = '0;
    forever begin
      @(negedge clk); #1;
      C_data_ready = 1'b0;
      if (!I_reset) begin
        phase = 0;
        C_ready = 1'b1;
      end else begin
        case (phase)
          0: begin
            if (C_exec) begin
              pw = C_write; pa = C_addr; cnt = lat;
              phase = hang ? 3 : 1;
              C_ready = 1'b1;
            end else begin
              C_ready = !hold_nr;
            end
          end
          1: phase = 2;
          2: begin
            C_ready = 1'b0;
            cnt--;
            if (cnt == 0) begin
              C_ready = 1'b1;
              if (!pw) begin
                C_data_ready = 1'b1;
                C_rdata = mem_word(pa);
              end
              phase = 0;
            end
          end
          default: C_ready = 1'b0;
        endcase
      end
    end
  end

  // Monitor: exec and ack scoreboards
  initial begin
    exe_t e;
    ack_t a;
    logic prev_f, prev_d;
    prev_f = 1'b0; prev_d = 1'b0;
    forever begin
      @(negedge clk);
      if (I_reset) begin
        if (C_exec) begin
          exec_hist.push_back(cyc);
          chk("busy_in_issue", O_busy, 1);
          if (exq.size() == 0) chk("exec_unexpected", 1, 0);
          else begin
            e = exq.pop_front();
            chk("exec_addr", C_addr, e.addr);
            chk("exec_write", C_write, e.wr);
            chk("exec_size", C_size, e.sz);
            chk("exec_data", C_data, e.data);
          end
        end
        if (F_ack) chk("f_ack_width", prev_f, 0);
        if (D_ack) chk("d_ack_width", prev_d, 0);
        if (F_ack || D_ack) begin
          ack_hist.push_back(cyc);
          chk("ack_both", F_ack & D_ack, 0);
          if (sbq.size() == 0) chk("ack_unexpected", 1, 0);
          else begin
            a = sbq.pop_front();
            chk("ack_port", D_ack, a.port);
            chk("ack_data", D_ack ? D_rdata : F_data, a.data);
            if (exec_hist.size() > 0)
              chk("ack_latency", cyc - exec_hist[exec_hist.size()-1], lat + 2);
          end
        end
      end
      prev_f = F_ack;
      prev_d = D_ack;
    end
  end

  // Drop each request on its ack (F may be kept for f_keep more acks) until idle
  task automatic serve(input int maxcyc, input int f_keep);
    bit done;
    done = 0;
    for (int i = 0; i < maxcyc && !done; i++) begin
      @(negedge clk);
      if (F_ack) begin
        if (f_keep > 0) f_keep--;
        else F_req = 1'b0;
      end
      if (D_ack) D_req = 1'b0;
      if (!F_req && !D_req && !O_busy) done = 1;
    end
    if (!done) begin
      chk("serve_timeout", 0, 1);
      F_req = 1'b0; D_req = 1'b0;
    end
  endtask

  initial begin
    int n0, a0, rel;
    bit seen;
    I_reset = 1'b0; F_req = 1'b0; F_addr = '0; D_req = 1'b0; D_write = 1'b0;
    D_size = '0; D_addr = '0; D_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", O_busy, 0);
    chk("rst_exec", C_exec, 0);
    chk("rst_f_ack", F_ack, 0);
    chk("rst_d_ack", D_ack, 0);
    chk("rst_f_data", F_data, 0);
    chk("rst_d_rdata", D_rdata, 0);
    chk("rst_c_fields", {C_write, C_size, C_addr, C_data}, 0);
    I_reset = 1'b1;
    @(negedge clk);

    // single fetch
    F_req = 1'b1; F_addr = 16'h0100;
    exq.push_back('{addr:16'h0100, wr:1'b0, sz:2'd1, data:16'h0000});
    sbq.push_back('{port:PORT_F, data:16'hBEEF});
    serve(60, 0);
    chk("fetch_exec_count", exec_hist.size(), 1);
    chk("fetch_ack_count", ack_hist.size(), 1);
    chk("f_data_hold", F_data, 16'hBEEF);

    // store: ack only after ready returns; D_rdata unchanged
    D_req = 1'b1; D_write = 1'b1; D_size = SIZE_WORD; D_addr = 16'h2000; D_data = 16'h1234;
    exq.push_back('{addr:16'h2000, wr:1'b1, sz:SIZE_WORD, data:16'h1234});
    sbq.push_back('{port:PORT_D, data:16'h0000});
    serve(60, 0);
    D_write = 1'b0;

    // simultaneous requests, held until served
    F_req = 1'b1; F_addr = 16'h0400;
    D_req = 1'b1; D_size = SIZE_HALF; D_addr = 16'h3000; D_data = 16'h7777;
`ifdef MEM_ARB_RR_EN
    exq.push_back('{addr:16'h0400, wr:1'b0, sz:2'd1, data:16'h0000});
    sbq.push_back('{port:PORT_F, data:mem_word(16'h0400)});
    exq.push_back('{addr:16'h3000, wr:1'b0, sz:SIZE_HALF, data:16'h7777});
    sbq.push_back('{port:PORT_D, data:mem_word(16'h3000)});
`else
    exq.push_back('{addr:16'h3000, wr:1'b0, sz:SIZE_HALF, data:16'h7777});
    sbq.push_back('{port:PORT_D, data:mem_word(16'h3000)});
    exq.push_back('{addr:16'h0400, wr:1'b0, sz:2'd1, data:16'h0000});
    sbq.push_back('{port:PORT_F, data:mem_word(16'h0400)});
`endif
    serve(120, 0);
    chk("tie_f_data", F_data, mem_word(16'h0400));
    chk("tie_d_rdata", D_rdata, mem_word(16'h3000));

    // controller not ready: no grant until ready returns
    hold_nr = 1'b1;
    repeat (2) @(negedge clk);
    D_req = 1'b1; D_size = SIZE_BYTE; D_addr = 16'h0042; D_data = 16'h0000;
    exq.push_back('{addr:16'h0042, wr:1'b0, sz:SIZE_BYTE, data:16'h0000});
    sbq.push_back('{port:PORT_D, data:mem_word(16'h0042)});
    n0 = exec_hist.size();
    repeat (5) begin
      @(negedge clk);
      chk("nr_idle_busy", O_busy, 0);
    end
    chk("nr_no_exec", exec_hist.size(), n0);
    rel = cyc;
    hold_nr = 1'b0;
    serve(60, 0);
    if (exec_hist.size() > n0) chk("nr_grant_cycle", exec_hist[n0] - rel, 1);
    else chk("nr_exec_missing", exec_hist.size(), n0 + 1);

    // back-to-back fetch with request held through the first ack
    F_req = 1'b1; F_addr = 16'h0500;
    repeat (2) begin
      exq.push_back('{addr:16'h0500, wr:1'b0, sz:2'd1, data:16'h0000});
      sbq.push_back('{port:PORT_F, data:mem_word(16'h0500)});
    end
    n0 = exec_hist.size();
    a0 = ack_hist.size();
    serve(120, 1);
    if (exec_hist.size() > n0 + 1 && ack_hist.size() > a0)
      chk("b2b_exec_gap", exec_hist[n0+1] - ack_hist[a0], 2);
    else chk("b2b_missing", exec_hist.size(), n0 + 2);

    // reset while a read hangs in WAIT: abandoned without ack
    hang = 1'b1;
    F_req = 1'b1; F_addr = 16'h0600;
    exq.push_back('{addr:16'h0600, wr:1'b0, sz:2'd1, data:16'h0000});
    n0 = exec_hist.size();
    a0 = ack_hist.size();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (exec_hist.size() > n0) seen = 1;
    end
    chk("hang_exec_seen", seen, 1);
    repeat (2) @(negedge clk);
    chk("hang_busy_wait", O_busy, 1);
    I_reset = 1'b0; F_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", O_busy, 0);
    chk("mid_rst_exec", C_exec, 0);
    chk("mid_rst_acks", {F_ack, D_ack}, 0);
    chk("mid_rst_f_data", F_data, 0);
    chk("mid_rst_c_addr", C_addr, 0);
    I_reset = 1'b1; hang = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_ack_after_rst", ack_hist.size(), a0);
    chk("sb_empty", sbq.size(), 0);
    chk("exq_empty", exq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
